// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Byte lanes are big-endian: byte offset 0 of a word is bits [31:24].
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  localparam logic [1:0] SIZE_4B = 2'd0;
  localparam logic [1:0] SIZE_1B = 2'd1;
  localparam logic [1:0] SIZE_2B = 2'd2;
  localparam logic [1:0] SIZE_3B = 2'd3;

  localparam int BLOCK_BITS = 256;
  localparam int OFFSET_W   = 5;

  function automatic logic [2:0] sizeBytes(input logic [1:0] size);
    return (size == SIZE_4B) ? 3'd4 : {1'b0, size};
  endfunction

  // Mask bit 3 is byte offset 0; lanes running past offset 3 are dropped.
  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < 4; k++)
      if (3'(k) >= {1'b0, off} && 3'(k) < ({1'b0, off} + sizeBytes(size)))
        m[3-k] = 1'b1;
    return m;
  endfunction

  // Moves the right-justified store data so its first byte lands on offset 'off'.
  function automatic logic [31:0] alignData(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] data);
    int sh;
    sh = 4 - int'(off) - int'(sizeBytes(size));
    if (sh >= 0) return data << (8 * sh);
    return data >> (-8 * sh);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port
// that either installs a whole line or merges a masked word.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic [$clog2(LINES)-1:0]             index,
  output logic                                 rdValid,
  output logic                                 rdDirty,
  output logic [32-OFFSET_W-$clog2(LINES)-1:0] rdTag,
  output logic [BLOCK_BITS-1:0]                rdData,
  input  logic                                 fillEn,
  input  logic [32-OFFSET_W-$clog2(LINES)-1:0] fillTag,
  input  logic [BLOCK_BITS-1:0]                fillData,
  input  logic                                 wordEn,
  input  logic [2:0]                           wordSel,
  input  logic [3:0]                           wordMask,
  input  logic [31:0]                          wordData,
  input  logic                                 cleanEn
);
  localparam int TAG_W = 32 - OFFSET_W - $clog2(LINES);

  logic [LINES-1:0]      valid, dirty;
  logic [TAG_W-1:0]      tags [LINES];
  logic [BLOCK_BITS-1:0] data [LINES];

  assign rdValid = valid[index];
  assign rdDirty = dirty[index];
  assign rdTag   = tags[index];
  assign rdData  = data[index];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid <= '0;
      dirty <= '0;
    end else if (fillEn) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (wordEn) begin
      dirty[index] <= 1'b1;
    end else if (cleanEn) begin
      dirty[index] <= 1'b0;
    end
  end

  // Payload arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      data[index] <= fillData;
      tags[index] <= fillTag;
    end else if (wordEn) begin
      for (int b = 0; b < 4; b++)
        if (wordMask[b]) data[index][32*wordSel + 8*b +: 8] <= wordData[8*b +: 8];
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Hits complete in one cycle; misses stall while block transfers run.
module data_cache
  import dcache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [31:0]           Address_IN,
  input  logic [31:0]           WriteData_IN,
  input  logic [1:0]            DataSize_IN,
  input  logic                  MemRead_IN,
  input  logic                  MemWrite_IN,
  output logic [31:0]           ReadData_OUT,
  output logic                  STALL_OUT,
  output logic [31:0]           BlockAddress_OUT,
  output logic                  MemBlockRead_OUT,
  output logic                  MemBlockWrite_OUT,
  output logic [BLOCK_BITS-1:0] DataBlock_OUT,
  input  logic [BLOCK_BITS-1:0] DataBlock_IN,
  input  logic                  MemBlockReady_IN
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 32 - OFFSET_W - INDEX_W;

  state_t state, stateNext;

  logic [INDEX_W-1:0]    index;
  logic [TAG_W-1:0]      tag, lineTag;
  logic [2:0]            wordSel;
  logic                  lineValid, lineDirty, hit, req, isWrite;
  logic [BLOCK_BITS-1:0] lineData;
  logic [31:0]           lineWord;
  logic                  fillEn, wordEn, cleanEn;

  assign wordSel  = Address_IN[4:2];
  assign index    = Address_IN[OFFSET_W +: INDEX_W];
  assign tag      = Address_IN[31 -: TAG_W];
  assign req      = MemRead_IN | MemWrite_IN;
  assign isWrite  = MemWrite_IN;
  assign hit      = lineValid && (lineTag == tag);
  assign lineWord = lineData[32*wordSel +: 32];

  dcache_line_store #(.LINES(LINES)) store (
    .clk      (CLOCK),
    .rstN     (RESET),
    .index    (index),
    .rdValid  (lineValid),
    .rdDirty  (lineDirty),
    .rdTag    (lineTag),
    .rdData   (lineData),
    .fillEn   (fillEn),
    .fillTag  (tag),
    .fillData (DataBlock_IN),
    .wordEn   (wordEn),
    .wordSel  (wordSel),
    .wordMask (byteEnable(DataSize_IN, Address_IN[1:0])),
    .wordData (alignData(DataSize_IN, Address_IN[1:0], WriteData_IN)),
    .cleanEn  (cleanEn)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= stateNext;
  end

  // Outputs are gated by RESET so they read zero while reset is held.
  always_comb begin
    stateNext         = state;
    STALL_OUT         = 1'b0;
    MemBlockRead_OUT  = 1'b0;
    MemBlockWrite_OUT = 1'b0;
    BlockAddress_OUT  = '0;
    DataBlock_OUT     = '0;
    ReadData_OUT      = '0;
    fillEn            = 1'b0;
    wordEn            = 1'b0;
    cleanEn           = 1'b0;
    if (RESET) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              ReadData_OUT = lineWord;
              wordEn       = isWrite;
            end else begin
              STALL_OUT = 1'b1;
              stateNext = (lineValid && lineDirty) ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          STALL_OUT         = 1'b1;
          MemBlockWrite_OUT = 1'b1;
          BlockAddress_OUT  = {lineTag, index, {OFFSET_W{1'b0}}};
          DataBlock_OUT     = lineData;
          if (MemBlockReady_IN) begin
            cleanEn   = 1'b1;
            stateNext = FILL;
          end
        end
        FILL: begin
          STALL_OUT        = 1'b1;
          MemBlockRead_OUT = 1'b1;
          BlockAddress_OUT = {Address_IN[31:OFFSET_W], {OFFSET_W{1'b0}}};
          if (MemBlockReady_IN) begin
            fillEn    = 1'b1;
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

endmodule
